// File: rtl/id_exe_stage.sv
// id_exe_stage: ID/EXE pipeline register with load-use bubble insertion, branch flush
// and downstream back-pressure. Optional stall statistics under `ID_EXE_STATS_EN`.
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 5
`endif

module id_exe_stage #(
    parameter int ADDR_W = `REG_FILE_ADDR_LEN,
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // Handshake: a transfer happens on a rising edge where valid && ready. The
    // producer holds its payload stable while valid && !ready; ready never waits on valid.
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [ADDR_W-1:0] id_src1,
    input  logic [ADDR_W-1:0] id_src2,
    input  logic [ADDR_W-1:0] id_st_src,
    input  logic [ADDR_W-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_rd_en,
    input  logic              id_mem_wr_en,
    input  logic [DATA_W-1:0] id_val1,
    input  logic [DATA_W-1:0] id_val2,
    input  logic [DATA_W-1:0] id_st_val,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              exe_ready,
    output logic              exe_valid,
    output logic [ADDR_W-1:0] exe_src1,
    output logic [ADDR_W-1:0] exe_src2,
    output logic [ADDR_W-1:0] exe_st_src,
    output logic [ADDR_W-1:0] exe_dest,
    output logic              exe_wb_en,
    output logic              exe_mem_rd_en,
    output logic              exe_mem_wr_en,
    output logic [DATA_W-1:0] exe_val1,
    output logic [DATA_W-1:0] exe_val2,
    output logic [DATA_W-1:0] exe_st_val,
    output logic [CTRL_W-1:0] exe_ctrl,
    output logic [1:0]        fsm_state,
`ifdef ID_EXE_STATS_EN
    output logic [15:0]       lu_bubble_cnt,
    output logic [15:0]       bp_stall_cnt,
`endif
    output logic              lu_stall
);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        LU_BUBBLE = 2'd2
    } state_t;

    state_t state_q;
    logic   advance;
    logic   fire;
    logic   dest_match;

    assign fsm_state = state_q;
    assign advance   = !exe_valid || exe_ready;

    // Register 0 is deliberately compared too, so this matches the forwarding unit.
    assign dest_match = (exe_dest == id_src1) || (exe_dest == id_src2) ||
                        (exe_dest == id_st_src);
    assign lu_stall   = id_valid && exe_valid && exe_mem_rd_en && exe_wb_en && dest_match;
    assign id_ready   = advance && !lu_stall && !flush;
    assign fire       = id_valid && id_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            exe_valid     <= 1'b0;
            exe_src1      <= '0;
            exe_src2      <= '0;
            exe_st_src    <= '0;
            exe_dest      <= '0;
            exe_wb_en     <= 1'b0;
            exe_mem_rd_en <= 1'b0;
            exe_mem_wr_en <= 1'b0;
            exe_val1      <= '0;
            exe_val2      <= '0;
            exe_st_val    <= '0;
            exe_ctrl      <= '0;
        end else if (flush) begin
            state_q       <= EMPTY;
            exe_valid     <= 1'b0;
            exe_wb_en     <= 1'b0;
            exe_mem_rd_en <= 1'b0;
            exe_mem_wr_en <= 1'b0;
        end else if (fire) begin
            state_q       <= FULL;
            exe_valid     <= 1'b1;
            exe_src1      <= id_src1;
            exe_src2      <= id_src2;
            exe_st_src    <= id_st_src;
            exe_dest      <= id_dest;
            exe_wb_en     <= id_wb_en;
            exe_mem_rd_en <= id_mem_rd_en;
            exe_mem_wr_en <= id_mem_wr_en;
            exe_val1      <= id_val1;
            exe_val2      <= id_val2;
            exe_st_val    <= id_st_val;
            exe_ctrl      <= id_ctrl;
        end else if (advance) begin
            // The load leaves for MEM; a bubble (never writing) takes its place.
            state_q       <= lu_stall ? LU_BUBBLE : EMPTY;
            exe_valid     <= 1'b0;
            exe_wb_en     <= 1'b0;
            exe_mem_rd_en <= 1'b0;
            exe_mem_wr_en <= 1'b0;
        end
    end

`ifdef ID_EXE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lu_bubble_cnt <= '0;
            bp_stall_cnt  <= '0;
        end else begin
            if (!flush && advance && lu_stall && lu_bubble_cnt != 16'hFFFF)
                lu_bubble_cnt <= lu_bubble_cnt + 16'd1;
            if (exe_valid && !exe_ready && bp_stall_cnt != 16'hFFFF)
                bp_stall_cnt <= bp_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/id_exe_stage.md
# id_exe_stage

ID/EXE pipeline register with load-use hazard detection and a valid/ready handshake. Sits between decode and execute; its registered `exe_src1`, `exe_src2`, `exe_st_src` feed EXE-stage operand forwarding, and its `exe_dest`/`exe_wb_en` move on to MEM. Forwarding cannot cover a load followed immediately by a consumer, so this block inserts exactly one bubble for that case. It also handles branch flush and downstream back-pressure.

## Interface
Parameters:
- `ADDR_W`, default `` `REG_FILE_ADDR_LEN ``: register-address width.
- `DATA_W`, default 32: operand width.
- `CTRL_W`, default 8: opaque EXE control bundle (ALU op, immediate select), passed through.

Ports:
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: synchronous, active-low reset.
- `id_valid  in  1`: decode holds an instruction.
- `id_ready  out  1`: this block accepts it this cycle.
- `id_src1`, `id_src2`, `id_st_src`, `id_dest  in  ADDR_W each`: register addresses.
- `id_wb_en`, `id_mem_rd_en`, `id_mem_wr_en  in  1 each`: writeback, load and store flags.
- `id_val1`, `id_val2`, `id_st_val  in  DATA_W each`: register-file read values.
- `id_ctrl  in  CTRL_W`: pass-through control.
- `flush  in  1`: EXE branch taken; kill the EXE slot.
- `exe_ready  in  1`: EXE/MEM accepts the current slot.
- `exe_valid  out  1`, plus registered `exe_*` copies of every `id_*` field (same widths).
- `lu_stall  out  1`: combinational; load-use hazard detected this cycle.

## Operation
- `advance = !exe_valid || exe_ready`.
- `lu_stall = id_valid && exe_valid && exe_mem_rd_en && exe_wb_en && (exe_dest == id_src1 || exe_dest == id_src2 || exe_dest == id_st_src)`.
  - Register 0 is not excluded, matching the forwarding compare.
- `id_ready = advance && !lu_stall && !flush`.
- `fire = id_valid && id_ready`.
- FSM, 2-bit state:
  - **EMPTY**: `exe_valid=0`.
  - **FULL**: `exe_valid=1`.
  - **LU_BUBBLE**: `exe_valid=0`; a load-use bubble is in flight.
- Transitions, in priority order:
  1. `flush` → EMPTY. The slot is cleared and nothing is captured.
  2. `fire` → FULL. All `exe_*` fields load from `id_*`.
  3. `advance && lu_stall` → LU_BUBBLE. `exe_valid` drops and the load moves on to MEM.
  4. `advance` (no fire) → EMPTY.
  5. Otherwise hold state and all fields (back-pressure).
- From LU_BUBBLE: no hazard is possible, because the EXE slot is empty. A valid `id` fires next cycle. The exceptions are `flush`, which goes to EMPTY, and `!id_valid`, which goes to EMPTY.
- When `exe_valid=0`, data fields keep their last values but are don't-care. Only `exe_wb_en`, `exe_mem_rd_en` and `exe_mem_wr_en` are forced to 0, so a bubble never writes.
- A held slot (`exe_valid && !exe_ready`) must keep every `exe_*` output bit-stable.

## Timing
- Reset (`rst_n=0` at a clock edge): state EMPTY; all `exe_*` outputs 0, including `exe_valid=0`. Counters are also 0.
- Reset wins over `flush` and `fire`.
- Reset mid-stall drops the held instruction.
- Latency: 1 cycle from `fire` to `exe_valid=1` with the data.
- Throughput: 1 per cycle with no hazard.
- Load-use costs exactly 1 bubble cycle.
- `id_ready` is combinational from `exe_ready`, `flush` and `exe_*`. It has no dependence on `id_valid`, apart from `lu_stall`, which is qualified by `id_valid`.
- `flush` in the same cycle as `lu_stall`: flush wins, the next state is EMPTY, and `id_ready=0`.
- `exe_ready=0` in the same cycle as `lu_stall`: hold FULL. Do not bubble yet.

## Configuration
- `ID_EXE_STATS_EN`:
  - Defined: adds outputs `lu_bubble_cnt` and `bp_stall_cnt`, each 16 bits, saturating at 16'hFFFF and reset to 0.
    - `lu_bubble_cnt` increments on each entry to LU_BUBBLE.
    - `bp_stall_cnt` increments on each cycle with `exe_valid && !exe_ready`.
  - Undefined: the ports and logic are absent. Handshake behaviour is identical.

## Test plan
- Reset: `rst_n=0` for 2 cycles with `id_valid=1` → `exe_valid=0`, all `exe_*` outputs 0, `id_ready=1` after release.
- Streaming: back-to-back ALU ops with `exe_ready=1` and `id_dest` values 3, 4, 5 → `exe_dest` shows 3, 4, 5 on consecutive cycles, one cycle behind `fire`.
- Load-use: load `dest=5` then `src1=5` → cycle N+1 `lu_stall=1`, `id_ready=0`. Cycle N+2 `exe_valid=0` (bubble), `exe_wb_en=0`. Cycle N+3 the consumer appears with `exe_src1=5`.
- Store-data hazard: load `dest=2` then store with `st_src=2` → 1 bubble inserted. Load `dest=2` then `src1=3`, `src2=4`, `st_src=6` → no bubble.
- Back-pressure: `exe_ready=0` for 3 cycles with `exe_val1=32'hDEADBEEF` → output stable and `id_ready=0`. With stats enabled, `bp_stall_cnt=3`.
- Flush: `flush=1` together with `lu_stall=1` and `id_valid=1` → `id_ready=0`, next cycle `exe_valid=0` with state EMPTY. A following valid instruction fires normally.
